// File: rtl/audio_outstage_if.sv
// Decoder-to-mixer bundle for audio_outstage: sample write handshake plus the output frame.
interface audio_outstage_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic                         mono;
    logic [SAMPLE_W-1:0]          in_sample;
    logic [CH_W-1:0]              in_channel;
    logic                         in_write;
    logic                         in_ready;
    logic [CHANNELS*SAMPLE_W-1:0] audio_out;
    logic                         out_strobe;

    modport master (
        output mono, in_sample, in_channel, in_write,
        input  in_ready, audio_out, out_strobe
    );

    modport slave (
        input  mono, in_sample, in_channel, in_write,
        output in_ready, audio_out, out_strobe
    );
endinterface

// File: rtl/audio_outstage.sv
// N-channel audio output stage: per-channel FIFOs, prime/arm/play sequencing, fade-to-zero, underrun/finish.
// Optional AUDIO_OUTSTAGE_VOLUME_EN adds a registered 8-bit volume multiply (0x80 = unity).
module audio_outstage #(
    parameter int CHANNELS    = 2,
    parameter int SAMPLE_W    = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int START_LEVEL = FIFO_DEPTH - 4,
    parameter int START_DELAY = 2,
    parameter int FADE_DIV    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_tick37_i,
    input  logic            sample_tick44_i,
    input  logic            audio_tick_i,
    input  logic [1:0]      rate_i,
    input  logic            source_idle_i,
    input  logic            notify_finish_i,
`ifdef AUDIO_OUTSTAGE_VOLUME_EN
    input  logic [7:0]      volume_i,
`endif
    audio_outstage_if.slave bus,
    output logic            playing_o,
    output logic            underrun_o,
    output logic            finished_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW = $clog2(START_DELAY + 1);
    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;

    logic [CHANNELS-1:0]               not_empty, primed, room, wr_en;
    logic [CHANNELS-1:0][SAMPLE_W-1:0] head, audio;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [FW-1:0] fade_cnt_q, fade_cnt_d;
    logic          tog18_q, fin_latch_q, fin_latch_d;
    logic          underrun_q, underrun_d, finished_q, finished_d, strobe_q;
    logic          rate_tick, frame_tick, pop, all_primed, ch_valid;
    logic          fade_step, fin_set, load;

    assign rate_tick  = (rate_i == 2'd2) ? sample_tick44_i : sample_tick37_i;
    // 18.9 kHz is every other 37.8 kHz tick, phased by the free-running toggle
    assign frame_tick = (rate_i == 2'd1) ? (sample_tick37_i && tog18_q) : rate_tick;
    assign all_primed = &primed;
    assign pop        = (state_q == S_PLAY) && frame_tick && (&not_empty);
    assign ch_valid   = 32'(bus.in_channel) < CHANNELS;
    // A same-cycle pop frees a slot, so room may be granted to a full FIFO
    assign bus.in_ready = bus.mono ? (&room) : (ch_valid && room[bus.in_channel]);

`ifdef AUDIO_OUTSTAGE_VOLUME_EN
    logic vld1_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld1_q <= 1'b0;
        else       vld1_q <= pop;
    end
    assign load = vld1_q;
`else
    assign load = pop;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0]       wptr_q, rptr_q;
        logic [AW:0]         cnt_q;
        logic [SAMPLE_W-1:0] aud_q, load_val;

        assign wr_en[c]     = bus.in_write && bus.in_ready && (bus.mono || (bus.in_channel == CW'(c)));
        assign not_empty[c] = (cnt_q != '0);
        assign primed[c]    = 32'(cnt_q) >= START_LEVEL;
        assign room[c]      = (cnt_q != FULL_CNT) || pop;
        assign head[c]      = mem_q[rptr_q];
        assign audio[c]     = aud_q;

        always_ff @(posedge clk) begin
            if (wr_en[c]) mem_q[wptr_q] <= bus.in_sample;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (wr_en[c]) wptr_q <= wptr_q + 1'b1;
                if (pop)      rptr_q <= rptr_q + 1'b1;
                if (wr_en[c] && !pop)      cnt_q <= cnt_q + 1'b1;
                else if (!wr_en[c] && pop) cnt_q <= cnt_q - 1'b1;
            end
        end

`ifdef AUDIO_OUTSTAGE_VOLUME_EN
        logic signed [SAMPLE_W+8:0] prod_q, shifted;
        always_ff @(posedge clk or posedge reset) begin
            if (reset)    prod_q <= '0;
            else if (pop) prod_q <= $signed(head[c]) * $signed({1'b0, volume_i});
        end
        assign shifted = prod_q >>> 7;
        // In range when every bit above the result's sign bit matches it
        assign load_val = (shifted[SAMPLE_W+8:SAMPLE_W-1] == {10{shifted[SAMPLE_W-1]}})
                        ? shifted[SAMPLE_W-1:0]
                        : (shifted[SAMPLE_W+8] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                               : {1'b0, {(SAMPLE_W-1){1'b1}}});
`else
        assign load_val = head[c];
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                aud_q <= '0;
            end else if (load) begin
                aud_q <= load_val;
            end else if (fade_step) begin
                if (aud_q[SAMPLE_W-1])  aud_q <= aud_q + 1'b1;
                else if (aud_q != '0)   aud_q <= aud_q - 1'b1;
            end
        end
    end

    assign fade_step  = (state_q != S_PLAY) && (32'(fade_cnt_q) == FADE_DIV - 1);
    assign fade_cnt_d = ((state_q == S_PLAY) || fade_step) ? '0 : fade_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        underrun_d = 1'b0;
        fin_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (all_primed) begin
                    state_d = S_ARMED;
                    dcnt_d  = '0;
                end
            end
            S_ARMED: begin
                if (!all_primed) begin
                    state_d = S_IDLE;
                end else if (rate_tick) begin
                    dcnt_d = dcnt_q + 1'b1;
                    if (32'(dcnt_q) + 1 == START_DELAY) state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (frame_tick && !(&not_empty)) begin
                    state_d    = S_IDLE;
                    underrun_d = !source_idle_i;
                    fin_set    = source_idle_i && notify_finish_i;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new end-of-playback event wins over a same-cycle clear, so it is never lost
    assign fin_latch_d = fin_set || (fin_latch_q && !audio_tick_i);
    assign finished_d  = audio_tick_i && fin_latch_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dcnt_q      <= '0;
            fade_cnt_q  <= '0;
            tog18_q     <= 1'b0;
            fin_latch_q <= 1'b0;
            underrun_q  <= 1'b0;
            finished_q  <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            fade_cnt_q  <= fade_cnt_d;
            tog18_q     <= tog18_q ^ sample_tick37_i;
            fin_latch_q <= fin_latch_d;
            underrun_q  <= underrun_d;
            finished_q  <= finished_d;
            strobe_q    <= load;
        end
    end

    assign bus.audio_out  = audio;
    assign bus.out_strobe = strobe_q;
    assign playing_o      = (state_q == S_PLAY);
    assign underrun_o     = underrun_q;
    assign finished_o     = finished_q;
endmodule

// File: doc/audio_outstage.md
# audio_outstage

Parametrised N-channel audio output stage between the ADPCM/PCM decoder and the audio mixer. It buffers decoded samples in per-channel FIFOs and holds playback until every FIFO is primed. Once playing, it releases one frame per sample tick at the selected 44.1/37.8/18.9 kHz rate. It also ramps the outputs to zero when idle, reports underruns, and raises an end-of-playback pulse aligned to the sector tick.

## Interface
Parameters:
- CHANNELS, 2, number of output channels (1..8)
- SAMPLE_W, 16, signed sample width
- FIFO_DEPTH, 32, entries per channel FIFO; power of two, ≥4
- START_LEVEL, FIFO_DEPTH-4, minimum fill per FIFO before arming; must be ≤ FIFO_DEPTH
- START_DELAY, 2, rate ticks spent in ARMED before PLAYING (≥1)
- FADE_DIV, 2, clocks per fade step (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_tick37  in  1  37.8 kHz single-cycle tick
- sample_tick44  in  1  44.1 kHz single-cycle tick
- audio_tick  in  1  sector-rate tick, single cycle
- rate  in  2  0=37.8 kHz, 1=18.9 kHz, 2=44.1 kHz, 3 treated as 0
- mono  in  1  1: each write goes to all channels; in_channel ignored
- in_sample  in  SAMPLE_W  signed sample from decoder
- in_channel  in  max(1,$clog2(CHANNELS))  target channel in multi-channel mode
- in_write  in  1  write strobe
- in_ready  out  1  target FIFO(s) not full
- source_idle  in  1  decoder has no sector in progress
- notify_finish  in  1  enables the finished pulse
- audio_out  out  CHANNELS*SAMPLE_W  packed outputs, channel 0 in LSBs
- out_strobe  out  1  new frame on audio_out
- playing  out  1  state == PLAYING
- underrun  out  1  one-cycle underrun pulse
- finished  out  1  one-cycle end-of-playback pulse

## Operation
- Each channel has its own FIFO with an occupancy counter of $clog2(FIFO_DEPTH)+1 bits.
- Write with the target FIFO full: the sample is dropped and the counter is unchanged.
- in_ready is combinational: mono → all FIFOs not full; multi-channel → FIFO[in_channel] not full.
- in_channel ≥ CHANNELS: the write is ignored.
- rate_tick = sample_tick44 if rate==2, else sample_tick37.
- tog18 toggles on every sample_tick37 and is free-running from reset.
- frame_tick = rate_tick, except rate==1: sample_tick37 && tog18.
- State machine:
  - IDLE: when every FIFO ≥ START_LEVEL, go to ARMED and clear dcnt.
  - ARMED: on each rate_tick, dcnt++. When dcnt reaches START_DELAY, go to PLAYING. If any FIFO drops below START_LEVEL, return to IDLE.
  - PLAYING: on frame_tick with all FIFOs non-empty, pop one word from every FIFO and register it into audio_out. On frame_tick with any FIFO empty, go to IDLE with no pop and no strobe. If source_idle==0 at that moment, pulse underrun.
- Fade: in IDLE/ARMED, every FADE_DIV clocks each channel moves 1 LSB toward zero. The step saturates at 0, never overshoots, and the most negative value moves to +1 toward zero.
- finished: on PLAYING→IDLE with source_idle && notify_finish, set a latch. The next audio_tick pulses finished and clears the latch. A further PLAYING→IDLE while latched still gives a single pulse.

## Timing
- Reset values: audio_out=0, out_strobe=0, playing=0, underrun=0, finished=0, all FIFOs empty, state IDLE, tog18=0, finish latch clear. in_ready=1 after reset.
- Write → visible in occupancy: next clock.
- A write and a pop on the same FIFO in the same clock leave the count unchanged. A pop frees space in the same cycle, so in_ready may be 1 while count==FIFO_DEPTH only when the pop occurs.
- frame_tick at cycle T → audio_out and out_strobe valid at T+1. out_strobe is high exactly one cycle.
- IDLE→ARMED: one cycle after the threshold is met.
- PLAYING: the first frame_tick after entry produces the first frame.
- underrun: asserted at T+1 for a failing frame_tick at T. playing deasserts in the same cycle.
- finished: asserted the cycle after the audio_tick that follows the latch.
- An asynchronous reset mid-operation discards all FIFO contents immediately, with no fade.

## Configuration
- AUDIO_OUTSTAGE_VOLUME_EN.
- Defined: adds input volume, 8 bits unsigned, with 0x80 = unity.
  - Each popped sample is multiplied by volume, arithmetically shifted right by 7, and saturated to SAMPLE_W. 0xFF ≈ +6 dB.
  - The multiply is registered, giving output latency T+2. out_strobe is delayed to match.
- Undefined: no volume port; samples pass unchanged at T+1.

## Test plan
- Stereo, START_LEVEL=28, START_DELAY=2, rate=0.
  - Write 28 samples per channel; playing rises on the 2nd sample_tick37 after priming.
  - out_strobe then follows each tick by 1 clock, with L/R matching write order.
- Mono, rate=1: each write fills both FIFOs equally; frames appear only on alternate sample_tick37; left==right.
- Underrun: after priming, stop writing with source_idle=0.
  - On the tick that finds a FIFO empty: underrun=1 for one cycle, playing=0, no strobe.
  - Same scenario with source_idle=1 and notify_finish=1: no underrun; finished pulses one clock after the next audio_tick.
- Fade: audio_out=+5/−3 at stop with FADE_DIV=2 → reaches 0/0 after 10/6 clocks, then holds at 0.
- Overflow: 40 writes to channel 0 with no playback → occupancy 32, in_ready=0, words 33..40 dropped, and first output frame = first written word.
- Reset asserted mid-PLAYING: all outputs 0 asynchronously, FIFOs empty; after release, playback needs full re-priming.
